// File: rtl/matrix_scan_controller.sv
// matrix_scan_controller: column-multiplexed scan of a 7x5 LED matrix (mirrored, 3 select lines)
// with per-slot blanking and a frame-boundary image latch.
module matrix_scan_controller #(
    parameter int DIVIDER      = 5000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [20:0] i_image,
    output logic [2:0]  o_col,
    output logic [6:0]  o_row,
    output logic        o_frame_done
);
    localparam int CW = $clog2(DIVIDER);
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [2:0]      r_col, w_col;
    logic [20:0]     r_img, w_img;
    logic [6:0]      r_row, w_row;
    logic            r_fd, w_fd;
    logic            w_wrap;
    assign w_wrap = r_cnt == CW'(DIVIDER - 1);
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_col   = r_col;
        w_img   = r_img;
        w_fd    = 1'b0;
        if (r_state == IDLE) begin
            if (i_enable) begin
                w_state = BLANK;
                w_cnt   = '0;
                w_col   = 3'b100;
                w_img   = i_image;
            end
        end else if (!i_enable) begin
            w_state = IDLE;
            w_cnt   = '0;
            w_col   = '0;
        end else begin
            w_cnt = w_wrap ? '0 : r_cnt + 1'b1;
            w_col = w_wrap ? {r_col[0], r_col[2], r_col[1]} : r_col;
            // a new frame starts when column 001 hands over to 100
            w_img = (w_wrap && r_col[0]) ? i_image : r_img;
            w_fd  = w_wrap && r_col[0];
        end
        if (w_state != IDLE)
            w_state = ({1'b0, w_cnt} + 1'b1 > (CW+1)'(BLANK_CYCLES)) ? SHOW : BLANK;
        w_row = (w_state != SHOW) ? '0 :
                w_col[2] ? w_img[20:14] :
                w_col[1] ? w_img[13:7] : w_img[6:0];
    end
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_col   <= '0;
            r_img   <= '0;
            r_row   <= '0;
            r_fd    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_col   <= w_col;
            r_img   <= w_img;
            r_row   <= w_row;
            r_fd    <= w_fd;
        end
    end
    assign o_col        = r_col;
    assign o_row        = r_row;
    assign o_frame_done = r_fd;
endmodule

// File: tb/tb_matrix_scan_controller.sv
// tb_matrix_scan_controller: scoreboard bench driving two configurations (8/2 and 4/0)
// against a frame-position reference model.
module tb_matrix_scan_controller;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [20:0] image = '0;
    logic [2:0]  col0, col1;
    logic [6:0]  row0, row1;
    logic        fd0, fd1;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    matrix_scan_controller #(.DIVIDER(8), .BLANK_CYCLES(2)) dut0 (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_image(image),
        .o_col(col0), .o_row(row0), .o_frame_done(fd0));
    matrix_scan_controller #(.DIVIDER(4), .BLANK_CYCLES(0)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_image(image),
        .o_col(col1), .o_row(row1), .o_frame_done(fd1));

    // model: position t within a 3*D-cycle frame
    int          dv[2] = '{8, 4};
    int          bk[2] = '{2, 0};
    bit          act[2], first[2];
    int          t[2];
    logic [20:0] mimg[2];
    logic [10:0] q0[$], q1[$];
    logic [10:0] e0, e1;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
        end
    endtask

    task automatic step_model(input int k);
        if (rst) begin
            act[k] = 0; t[k] = 0; first[k] = 0; mimg[k] = '0;
        end else if (!act[k]) begin
            if (en) begin act[k] = 1; t[k] = 0; first[k] = 1; mimg[k] = image; end
        end else if (!en) begin
            act[k] = 0;
        end else begin
            t[k]++;
            if (t[k] == 3 * dv[k]) begin t[k] = 0; first[k] = 0; mimg[k] = image; end
        end
    endtask

    function automatic logic [10:0] expv(input int k);
        int s, c;
        logic [2:0] ec;
        logic [6:0] er;
        if (!act[k]) return '0;
        s  = t[k] / dv[k];
        c  = t[k] % dv[k];
        ec = 3'b100 >> s;
        er = (c >= bk[k]) ? mimg[k][(2 - s) * 7 +: 7] : 7'd0;
        return {ec, er, (t[k] == 0 && !first[k])};
    endfunction

    always @(posedge clk) begin
        step_model(0);
        step_model(1);
        q0.push_back(expv(0));
        q1.push_back(expv(1));
    end

    always @(posedge clk) begin
        #1;
        if (q0.size() == 0 || q1.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty got=0 exp=1");
        end else begin
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            chk("col0", col0, e0[10:8]);
            chk("row0", row0, e0[7:1]);
            chk("fd0", fd0, e0[0]);
            chk("col1", col1, e1[10:8]);
            chk("row1", row1, e1[7:1]);
            chk("fd1", fd1, e1[0]);
        end
    end

    initial begin
        int n, fdc;
        bit found;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // full-on image: first frame_done 25 cycles after enable
        image = 21'h1FFFFF;
        en = 1'b1;
        n = 0;
        found = 0;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(negedge clk);
            if (fd0) begin found = 1; n = i; end
        end
        chk("fd_latency", n, 25);
        // asynchronous reset in the middle of a 010 SHOW slot
        repeat (10) @(negedge clk);
        chk("pre_rst_col", col0, 3'b010);
        #2 rst = 1'b1; en = 1'b0;
        #1;
        chk("async_col0", col0, 0);
        chk("async_row0", row0, 0);
        chk("async_fd0", fd0, 0);
        chk("async_col1", col1, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        // image change mid-frame must not tear
        image = 21'h000001;
        en = 1'b1;
        repeat (10) @(negedge clk);
        image = 21'h1FC000;
        repeat (30) @(negedge clk);
        // drop enable during col=001 cnt=5, then restart
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        repeat (22) @(negedge clk);
        chk("pre_drop_col", col0, 3'b001);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (40) @(negedge clk);
        // long run: 1000 frames with random image writes
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        fdc = 0;
        for (int i = 0; i < 24000; i++) begin
            @(negedge clk);
            if (fd0) fdc++;
            chk("onehot", {31'd0, $onehot(col0)}, 1);
            if ($urandom_range(0, 9) == 0) image = 21'($urandom);
        end
        chk("fd_count", fdc, 999);
        en = 1'b0;
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
